// File: rtl/fadd_norm_arb_if.sv
// fadd_norm_arb_if: request, shared-LZA and result buses of the FADD_36 normalization arbiter.
interface fadd_norm_arb_if #(parameter int W = 37, parameter int EW = 9);
    logic [1:0]      i_req_vld;
    logic [1:0]      o_req_rdy;
    logic [2*W-1:0]  i_req_op_a;
    logic [2*W-1:0]  i_req_op_b;
    logic [2*W-1:0]  i_req_sum;
    logic [2*EW-1:0] i_req_exp;
    logic [W-1:0]    o_lza_a;
    logic [W-1:0]    o_lza_b;
    logic [5:0]      i_lza_num;
    logic            i_lza_corr;
    logic            o_res_vld;
    logic            i_res_rdy;
    logic            o_res_id;
    logic [W-1:0]    o_res_man;
    logic [EW-1:0]   o_res_exp;
    logic            o_res_zero;
    logic            o_res_uf;
    modport slave (
        input  i_req_vld, i_req_op_a, i_req_op_b, i_req_sum, i_req_exp, i_lza_num, i_lza_corr, i_res_rdy,
        output o_req_rdy, o_lza_a, o_lza_b, o_res_vld, o_res_id, o_res_man, o_res_exp, o_res_zero, o_res_uf
    );
    modport master (
        output i_req_vld, i_req_op_a, i_req_op_b, i_req_sum, i_req_exp, i_lza_num, i_lza_corr, i_res_rdy,
        input  o_req_rdy, o_lza_a, o_lza_b, o_res_vld, o_res_id, o_res_man, o_res_exp, o_res_zero, o_res_uf
    );
endinterface

// File: rtl/fadd_norm_arb.sv
// fadd_norm_arb: round-robin arbiter sharing one LZA and normalization shifter between the
// sine and cosine subtract paths; two-stage pipeline (capture, shift/adjust) with valid/ready output.
module fadd_norm_arb #(parameter int W = 37, parameter int EW = 9) (
    input  logic           i_clk,
    input  logic           i_rst,
    fadd_norm_arb_if.slave io_bus
);
    logic          w_any, w_gid, w_s2_load, w_s1_free, w_acc, w_zero, w_uf;
    logic [6:0]    w_sh;
    logic [W-1:0]  w_man;
    logic [EW-1:0] w_exp;
    logic          r_lg, r_s1_vld, r_s1_corr, r_s1_id, r_s2_vld, r_s2_id, r_s2_zero, r_s2_uf;
    logic [5:0]    r_s1_num;
    logic [W-1:0]  r_s1_sum, r_s2_man;
    logic [EW-1:0] r_s1_exp, r_s2_exp;

    // Both valid: grant the requester that did not win last; otherwise grant the lone one.
    assign w_any     = |io_bus.i_req_vld & !i_rst;
    assign w_gid     = &io_bus.i_req_vld ? !r_lg : io_bus.i_req_vld[1];
    assign w_s2_load = r_s1_vld & (!r_s2_vld | io_bus.i_res_rdy);
    assign w_s1_free = !r_s1_vld | w_s2_load;
    assign io_bus.o_req_rdy = {w_any & w_s1_free & w_gid, w_any & w_s1_free & !w_gid};
    assign w_acc     = |(io_bus.i_req_vld & io_bus.o_req_rdy);
    assign io_bus.o_lza_a = !w_any ? '0 : w_gid ? io_bus.i_req_op_a[2*W-1:W] : io_bus.i_req_op_a[W-1:0];
    assign io_bus.o_lza_b = !w_any ? '0 : w_gid ? io_bus.i_req_op_b[2*W-1:W] : io_bus.i_req_op_b[W-1:0];

    // Shift amounts of W or more naturally flush the mantissa to zero.
    assign w_sh   = {1'b0, r_s1_num} + 7'(r_s1_corr);
    assign w_zero = r_s1_sum == '0;
    assign w_uf   = !w_zero & (EW'(w_sh) >= r_s1_exp);
    assign w_man  = (w_zero | w_uf) ? '0 : r_s1_sum << w_sh;
    assign w_exp  = (w_zero | w_uf) ? '0 : r_s1_exp - EW'(w_sh);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lg      <= 1'b1;
            r_s1_vld  <= 1'b0;
            r_s1_num  <= '0;
            r_s1_corr <= 1'b0;
            r_s1_sum  <= '0;
            r_s1_exp  <= '0;
            r_s1_id   <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_id   <= 1'b0;
            r_s2_man  <= '0;
            r_s2_exp  <= '0;
            r_s2_zero <= 1'b0;
            r_s2_uf   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_lg      <= w_gid;
                r_s1_num  <= io_bus.i_lza_num;
                r_s1_corr <= io_bus.i_lza_corr;
                r_s1_sum  <= w_gid ? io_bus.i_req_sum[2*W-1:W] : io_bus.i_req_sum[W-1:0];
                r_s1_exp  <= w_gid ? io_bus.i_req_exp[2*EW-1:EW] : io_bus.i_req_exp[EW-1:0];
                r_s1_id   <= w_gid;
            end
            r_s1_vld <= w_acc | (r_s1_vld & !w_s2_load);
            if (w_s2_load) begin
                r_s2_id   <= r_s1_id;
                r_s2_man  <= w_man;
                r_s2_exp  <= w_exp;
                r_s2_zero <= w_zero;
                r_s2_uf   <= w_uf;
            end
            r_s2_vld <= w_s2_load | (r_s2_vld & !io_bus.i_res_rdy);
        end
    end

    assign io_bus.o_res_vld  = r_s2_vld;
    assign io_bus.o_res_id   = r_s2_id;
    assign io_bus.o_res_man  = r_s2_man;
    assign io_bus.o_res_exp  = r_s2_exp;
    assign io_bus.o_res_zero = r_s2_zero;
    assign io_bus.o_res_uf   = r_s2_uf;
endmodule

// File: tb/tb_fadd_norm_arb.sv
// tb_fadd_norm_arb: directed checks of arbitration, normalization arithmetic, backpressure and reset.
module tb_fadd_norm_arb;
    localparam int W = 37;
    localparam int EW = 9;
    localparam logic [W-1:0] A0 = 37'h0_0AAA_0001, A1 = 37'h1_5555_0002;
    localparam logic [W-1:0] B0 = 37'h0_0F0F_0003, B1 = 37'h1_F0F0_0004;
    localparam logic [W-1:0] M0 = 37'h8_0000_0000, M1 = 37'h10_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acc = 0;

    always #5 clk = ~clk;

    fadd_norm_arb_if #(.W(W), .EW(EW)) bus ();
    fadd_norm_arb #(.W(W), .EW(EW)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int r, input logic [W-1:0] sum, input logic [EW-1:0] e,
                       input logic [5:0] num, input logic corr);
        bus.i_req_vld = (r == 1) ? 2'b10 : 2'b01;
        bus.i_req_sum[W*r +: W] = sum;
        bus.i_req_exp[EW*r +: EW] = e;
        bus.i_lza_num = num;
        bus.i_lza_corr = corr;
    endtask

    task automatic res(input string t, input logic id, input logic [W-1:0] man,
                       input logic [EW-1:0] e, input logic z, input logic u);
        chk({t, "_vld"}, bus.o_res_vld, 1);
        chk({t, "_id"}, bus.o_res_id, id);
        chk({t, "_man"}, bus.o_res_man, man);
        chk({t, "_exp"}, bus.o_res_exp, e);
        chk({t, "_zero"}, bus.o_res_zero, z);
        chk({t, "_uf"}, bus.o_res_uf, u);
    endtask

    task automatic single(input string t, input int r, input logic [W-1:0] sum, input logic [EW-1:0] e,
                          input logic [5:0] num, input logic corr, input logic [W-1:0] xm,
                          input logic [EW-1:0] xe, input logic xz, input logic xu);
        req(r, sum, e, num, corr);
        #1;
        chk({t, "_rdy"}, bus.o_req_rdy, (r == 1) ? 2'b10 : 2'b01);
        chk({t, "_lza_a"}, bus.o_lza_a, (r == 1) ? A1 : A0);
        chk({t, "_lza_b"}, bus.o_lza_b, (r == 1) ? B1 : B0);
        tick;
        bus.i_req_vld = 2'b00;
        chk({t, "_s1only"}, bus.o_res_vld, 0);
        tick;
        res(t, (r == 1), xm, xe, xz, xu);
        tick;
        chk({t, "_pop"}, bus.o_res_vld, 0);
    endtask

    initial begin
        bus.i_req_vld = 2'b00;
        bus.i_req_op_a = {A1, A0};
        bus.i_req_op_b = {B1, B0};
        bus.i_req_sum = '0;
        bus.i_req_exp = '0;
        bus.i_lza_num = '0;
        bus.i_lza_corr = 1'b0;
        bus.i_res_rdy = 1'b1;
        tick;
        tick;
        bus.i_req_vld = 2'b11;
        #1;
        chk("rst_rdy", bus.o_req_rdy, 0);
        chk("rst_lza_a", bus.o_lza_a, 0);
        chk("rst_lza_b", bus.o_lza_b, 0);
        bus.i_req_vld = 2'b00;
        rst = 1'b0;
        #1;
        chk("rst_vld", bus.o_res_vld, 0);
        chk("rst_id", bus.o_res_id, 0);
        chk("rst_man", bus.o_res_man, 0);
        chk("rst_exp", bus.o_res_exp, 0);
        chk("rst_zero", bus.o_res_zero, 0);
        chk("rst_uf", bus.o_res_uf, 0);

        single("basic", 0, 37'h1234, 9'd100, 6'd23, 1'b0, 37'h9_1A00_0000, 9'd77, 1'b0, 1'b0);
        single("corr", 1, 37'h1234, 9'd100, 6'd22, 1'b1, 37'h9_1A00_0000, 9'd77, 1'b0, 1'b0);
        single("zero", 0, 37'h0, 9'd50, 6'd3, 1'b0, 37'h0, 9'd0, 1'b1, 1'b0);
        single("uf_eq", 0, 37'h10, 9'd5, 6'd5, 1'b0, 37'h0, 9'd0, 1'b0, 1'b1);
        single("uf_corr", 0, 37'h1, 9'd6, 6'd5, 1'b1, 37'h0, 9'd0, 1'b0, 1'b1);
        single("exp_one", 0, 37'h1, 9'd6, 6'd5, 1'b0, 37'h20, 9'd1, 1'b0, 1'b0);
        single("big_sh", 0, 37'h1, 9'd200, 6'd63, 1'b0, 37'h0, 9'd137, 1'b0, 1'b0);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.i_req_sum = {37'd2, 37'd1};
        bus.i_req_exp = {9'd200, 9'd100};
        bus.i_lza_num = 6'd35;
        bus.i_lza_corr = 1'b0;
        bus.i_req_vld = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("alt_rdy%0d", i), bus.o_req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick;
            if (i >= 1) begin
                chk($sformatf("alt_vld%0d", i), bus.o_res_vld, 1);
                chk($sformatf("alt_id%0d", i), bus.o_res_id, (i - 1) % 2);
                chk($sformatf("alt_man%0d", i), bus.o_res_man, ((i - 1) % 2 == 1) ? M1 : M0);
                chk($sformatf("alt_exp%0d", i), bus.o_res_exp, ((i - 1) % 2 == 1) ? 165 : 65);
            end
        end
        bus.i_req_vld = 2'b00;
        tick;
        tick;
        chk("alt_drained", bus.o_res_vld, 0);

        bus.i_res_rdy = 1'b0;
        bus.i_req_vld = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_rdy%0d", c), bus.o_req_rdy, (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00);
            acc += int'(|(bus.i_req_vld & bus.o_req_rdy));
            tick;
            if (c >= 1) begin
                chk($sformatf("bp_vld%0d", c), bus.o_res_vld, 1);
                chk($sformatf("bp_id%0d", c), bus.o_res_id, 0);
                chk($sformatf("bp_man%0d", c), bus.o_res_man, M0);
                chk($sformatf("bp_exp%0d", c), bus.o_res_exp, 65);
            end
        end
        chk("bp_accepted", acc, 2);
        bus.i_req_vld = 2'b00;
        bus.i_res_rdy = 1'b1;
        tick;
        chk("bp_second_vld", bus.o_res_vld, 1);
        chk("bp_second_id", bus.o_res_id, 1);
        chk("bp_second_man", bus.o_res_man, M1);
        chk("bp_second_exp", bus.o_res_exp, 165);
        tick;
        chk("bp_empty", bus.o_res_vld, 0);

        bus.i_res_rdy = 1'b0;
        bus.i_req_vld = 2'b11;
        tick;
        tick;
        chk("flight_vld", bus.o_res_vld, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", bus.o_res_vld, 0);
        chk("mid_rst_man", bus.o_res_man, 0);
        chk("mid_rst_id", bus.o_res_id, 0);
        chk("mid_rst_rdy", bus.o_req_rdy, 2'b01);
        tick;
        bus.i_req_vld = 2'b00;
        bus.i_res_rdy = 1'b1;
        tick;
        chk("post_rst_vld", bus.o_res_vld, 1);
        chk("post_rst_id", bus.o_res_id, 0);
        chk("post_rst_man", bus.o_res_man, M0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
